// File: rtl/var_delay_line_if.sv
// rtl/var_delay_line_if.sv - sample/length bus for var_delay_line
// master drives samples and length loads; slave returns delayed samples.
interface var_delay_line_if #(
  parameter int DW      = 8,
  parameter int CH      = 1,
  parameter int MAX_LEN = 32
);
  localparam int LW = $clog2(MAX_LEN + 1);

  logic                 en;
  logic [CH*DW-1:0]     din;
  logic                 len_we;
  logic [LW-1:0]        len;
  logic [CH*DW-1:0]     dout;
  logic                 dout_valid;
  logic [LW-1:0]        len_cur;

  modport master (
    output en, din, len_we, len,
    input  dout, dout_valid, len_cur
  );

  modport slave (
    input  en, din, len_we, len,
    output dout, dout_valid, len_cur
  );
endinterface

// File: rtl/var_delay_line.sv
// rtl/var_delay_line.sv - runtime-programmable multi-lane delay line
// Circular buffer with one write pointer; dout is primed by a fill counter.
module var_delay_line #(
  parameter int DW       = 8,
  parameter int CH       = 1,
  parameter int MAX_LEN  = 32,
  parameter int INIT_LEN = MAX_LEN
) (
  input  logic               clk,
  input  logic               rst,
  var_delay_line_if.slave    bus
);
  localparam int W  = CH * DW;
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int PW = $clog2(MAX_LEN);

  localparam logic [LW-1:0] C_MAX   = LW'(MAX_LEN);
  localparam logic [LW-1:0] C_INIT  = LW'(INIT_LEN);
  localparam logic [LW-1:0] C_ONE   = LW'(1);
  localparam logic [PW-1:0] C_PLAST = PW'(MAX_LEN - 1);

  logic [W-1:0]  r_mem [MAX_LEN];
  logic [PW-1:0] r_wptr;
  logic [LW-1:0] r_fill;
  logic [LW-1:0] r_len;
  logic [W-1:0]  r_dout;
  logic          r_valid;

  logic [LW-1:0] w_eff_len;
  logic [LW-1:0] w_fill_base;
  logic [LW-1:0] w_fill_nxt;
  logic [LW:0]   w_rsum;
  logic [PW-1:0] w_raddr;
  logic [W-1:0]  w_rdata;

  always_comb begin
    w_eff_len = r_len;
    if (bus.len_we) begin
      if (bus.len == '0)
        w_eff_len = C_ONE;
      else if (bus.len > C_MAX)
        w_eff_len = C_MAX;
      else
        w_eff_len = bus.len;
    end

    // a load on this edge restarts the fill, and this edge's sample counts as the first
    w_fill_base = bus.len_we ? '0 : r_fill;
    w_fill_nxt  = (w_fill_base < w_eff_len) ? w_fill_base + C_ONE : w_fill_base;

    // sample n-L+1 sits L-1 slots behind the write pointer, modulo MAX_LEN
    w_rsum = {{(LW + 1 - PW){1'b0}}, r_wptr} + {1'b0, C_MAX} - {1'b0, w_eff_len} + (LW + 1)'(1);
    if (w_rsum >= {1'b0, C_MAX})
      w_rsum = w_rsum - {1'b0, C_MAX};
    w_raddr = w_rsum[PW-1:0];
    w_rdata = r_mem[w_raddr];
  end

  always_ff @(posedge clk) begin
    if (bus.en)
      r_mem[r_wptr] <= bus.din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_fill  <= '0;
      r_len   <= C_INIT;
      r_dout  <= '0;
      r_valid <= 1'b0;
    end else begin
      if (bus.len_we)
        r_len <= w_eff_len;
      if (bus.en) begin
        r_wptr <= (r_wptr == C_PLAST) ? '0 : r_wptr + PW'(1);
        r_fill <= w_fill_nxt;
        if (w_fill_nxt == w_eff_len) begin
          // L=1 has no memory delay, and the read slot would equal the write slot
          r_dout  <= (w_eff_len == C_ONE) ? bus.din : w_rdata;
          r_valid <= 1'b1;
        end else begin
          r_dout  <= '0;
          r_valid <= 1'b0;
        end
      end else if (bus.len_we) begin
        r_fill  <= '0;
        r_dout  <= '0;
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_valid;
  assign bus.len_cur    = r_len;
endmodule

// File: tb/tb_var_delay_line.sv
// tb/tb_var_delay_line.sv - scoreboard bench for var_delay_line
// Reference keeps the accepted-sample history since the last flush.
module tb_var_delay_line;
  localparam int DW       = 8;
  localparam int CH       = 2;
  localparam int MAX_LEN  = 16;
  localparam int INIT_LEN = 4;
  localparam int LW       = 5;
  localparam int W        = CH * DW;

  typedef struct {
    logic [W-1:0]  dout;
    logic          valid;
    logic [LW-1:0] len;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  var_delay_line_if #(.DW(DW), .CH(CH), .MAX_LEN(MAX_LEN)) bus ();

  var_delay_line #(.DW(DW), .CH(CH), .MAX_LEN(MAX_LEN), .INIT_LEN(INIT_LEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t         exp_q[$];
  logic [W-1:0] hist[$];
  int           m_len;
  int           checks   = 0;
  int           failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [W-1:0] smp(input int n);
    logic [7:0] b;
    b = 8'(n);
    return {~b, b};
  endfunction

  task automatic drive(input logic e, input logic [W-1:0] d, input logic we, input logic [LW-1:0] l);
    exp_t x;
    @(negedge clk);
    bus.en     = e;
    bus.din    = d;
    bus.len_we = we;
    bus.len    = l;
    if (we) begin
      m_len = (l == 0) ? 1 : (int'(l) > MAX_LEN) ? MAX_LEN : int'(l);
      hist.delete();
    end
    if (e) begin
      hist.push_back(d);
      if (hist.size() > MAX_LEN) void'(hist.pop_front());
    end
    if (hist.size() >= m_len) begin
      x.dout  = hist[hist.size() - m_len];
      x.valid = 1'b1;
    end else begin
      x.dout  = '0;
      x.valid = 1'b0;
    end
    x.len = LW'(m_len);
    exp_q.push_back(x);
    @(posedge clk);
  endtask

  initial begin
    bit   have;
    exp_t x;
    forever begin
      @(posedge clk);
      have = (exp_q.size() != 0);
      @(negedge clk);
      if (have) begin
        x = exp_q.pop_front();
        chk("dout", 32'(bus.dout), 32'(x.dout));
        chk("dout_valid", 32'(bus.dout_valid), 32'(x.valid));
        chk("len_cur", 32'(bus.len_cur), 32'(x.len));
      end
    end
  end

  initial begin
    logic e_r, we_r;
    int   l_r;
    rst        = 1'b1;
    bus.en     = 1'b0;
    bus.din    = '0;
    bus.len_we = 1'b0;
    bus.len    = '0;
    m_len      = INIT_LEN;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_dout", 32'(bus.dout), 32'h0);
    chk("reset_valid", 32'(bus.dout_valid), 32'h0);
    chk("reset_len_cur", 32'(bus.len_cur), 32'(INIT_LEN));
    #1 rst = 1'b1;

    for (int n = 1; n <= 10; n++) drive(1'b1, smp(n), 1'b0, 5'd0);
    repeat (3) drive(1'b0, W'($urandom), 1'b0, 5'd0);
    for (int n = 11; n <= 20; n++) drive(1'b1, smp(n), 1'b0, 5'd0);

    drive(1'b1, {8'($urandom), 8'h55}, 1'b1, 5'd1);
    repeat (5) drive(1'b1, W'($urandom), 1'b0, 5'd0);

    drive(1'b0, '0, 1'b1, 5'd16);
    for (int n = 1; n <= 40; n++) drive(1'b1, smp(n), 1'b0, 5'd0);

    drive(1'b0, '0, 1'b1, 5'd0);
    repeat (3) drive(1'b1, W'($urandom), 1'b0, 5'd0);
    drive(1'b0, '0, 1'b1, 5'd20);
    repeat (20) drive(1'b1, W'($urandom), 1'b0, 5'd0);

    repeat (400) begin
      e_r  = ($urandom_range(0, 9) < 7);
      we_r = ($urandom_range(0, 29) == 0);
      l_r  = $urandom_range(0, 31);
      drive(e_r, W'($urandom), we_r, LW'(l_r));
    end

    drive(1'b0, '0, 1'b1, 5'd4);
    for (int n = 1; n <= 8; n++) drive(1'b1, smp(n), 1'b0, 5'd0);

    @(negedge clk);
    #1;
    chk("pre_reset_valid", 32'(bus.dout_valid), 32'(hist.size() >= m_len));
    rst        = 1'b0;
    bus.en     = 1'b0;
    bus.len_we = 1'b0;
    #1;
    chk("async_reset_dout", 32'(bus.dout), 32'h0);
    chk("async_reset_valid", 32'(bus.dout_valid), 32'h0);
    chk("async_reset_len_cur", 32'(bus.len_cur), 32'(INIT_LEN));
    m_len = INIT_LEN;
    hist.delete();
    @(negedge clk);
    #1 rst = 1'b1;
    for (int n = 1; n <= 6; n++) drive(1'b1, smp(n + 100), 1'b0, 5'd0);

    repeat (3) @(negedge clk);
    #1;
    chk("scoreboard_drain", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
